voice_rom_scheduler: RTL
========================

Name: voice_rom_scheduler

Overview:
- Round-robin scheduler that time-shares one synchronous waveform ROM port among NUM_VOICES voices.
- Replaces the free-running per-ROM slot counter plus enable-gated capture registers.
- Each cycle it issues one read for the next enabled voice and tracks the in-flight read through the ROM latency.
- It steers the returned sample into that voice's holding register and flags a frame boundary once every enabled voice has refreshed.

Parameters:
NUM_VOICES, 3, number of voices sharing the ROM (2..8)
ADDR_W, 12, ROM address width
DATA_W, 8, ROM data / sample width
ROM_LAT, 1, ROM read latency in cycles (1..4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
voice_en  input  NUM_VOICES  per-voice enable (nonzero note); bit i = voice i
voice_addrs  input  NUM_VOICES*ADDR_W  per-voice ROM address, voice i at [i*ADDR_W +: ADDR_W]
rom_en  output  1  ROM read strobe (registered)
rom_addr  output  ADDR_W  ROM read address (registered)
rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after the issue cycle
samples  output  NUM_VOICES*DATA_W  per-voice held sample, voice i at [i*DATA_W +: DATA_W]
sample_upd  output  NUM_VOICES  one-cycle pulse: samples slice i updated this cycle
frame_done  output  1  one-cycle pulse: last voice of a pass written
cur_voice  output  3  voice index of the current issue (valid when rom_en=1)

Behaviour:
- Reset (async assert, sync release) clears the following:
  - rom_en, rom_addr, samples, sample_upd, frame_done and cur_voice go to 0.
  - The in-flight tag pipeline empties.
  - The issue pointer ptr goes to NUM_VOICES-1, so the first issue selects voice 0.
  - The state goes to IDLE.
- States:
  - IDLE: voice_en == 0, rom_en = 0.
  - RUN: at least one voice is enabled.
  - IDLE->RUN on the first edge where voice_en != 0.
  - RUN->IDLE on any edge where voice_en == 0. Entering IDLE also sets ptr to NUM_VOICES-1.
- Issue (RUN, each edge):
  - nxt = first enabled index searching ptr+1, ptr+2, ... modulo NUM_VOICES. If only ptr is enabled, nxt = ptr.
  - Registers rom_en=1, rom_addr=voice_addrs[nxt], cur_voice=nxt, ptr=nxt.
  - The address is sampled at the issue edge; later changes do not affect that read.
- Issue cycle t = the cycle in which rom_en=1 is visible.
- Tag: {valid, voice, last} pushed into a ROM_LAT-deep shift register at the issue edge.
  - last=1 if no enabled index exists above nxt at issue time (pass wrap).
- Capture:
  - When a tag reaches depth ROM_LAT, rom_data is valid in cycle t+ROM_LAT.
  - At the edge ending that cycle, samples[voice] <= rom_data, provided voice_en[voice] is still 1.
  - In cycle t+ROM_LAT+1: sample_upd[voice]=1, and frame_done=tag.last.
  - Total issue-to-visible latency = ROM_LAT+1 cycles.
- Throughput: one read per cycle. Each voice is refreshed every popcount(voice_en) cycles in steady state.
- Disable: a falling voice_en[i] clears samples slice i to 0 at the next edge.
  - Any in-flight tag for voice i is discarded: no write, no sample_upd.
  - If a discarded tag has last=1, frame_done still pulses.
- Enable mid-pass: the voice is picked up by the normal search; there is no restart of the pass.
- Simultaneous capture and issue for the same voice is legal. The capture writes the older data; the new read lands later.
- At most one sample_upd bit is set per cycle.
- Reset mid-operation: outputs drop immediately and in-flight reads are lost. After release the bench sees the first issue to the lowest enabled voice.
- Unused cur_voice bits (NUM_VOICES<=4) are 0.

Test Plan:
- ROM model data = addr[7:0], ROM_LAT=1, voice_en=3'b111, addrs 0x010/0x020/0x030:
  - Response: rom_addr sequence 0x010,0x020,0x030,... with cur_voice 0,1,2.
  - samples = 0x30_20_10 by cycle 5.
  - sample_upd 001,010,100 repeating; frame_done every 3rd cycle, coincident with upd=100.
- voice_en=3'b010 only:
  - Response: every cycle rom_addr=0x020 and sample_upd=010.
  - frame_done=1 continuously from the 2nd cycle after issue; samples slices 0 and 2 = 0.
- voice_en=3'b101: issues alternate voice 0 and voice 2; frame_done pulses with each voice-2 update; voice 1 is never issued.
- Steady all-enabled; drop voice_en[2] in the cycle voice 2 is issued:
  - Response: no sample_upd[2]; samples[23:16]=0 next cycle.
  - frame_done still pulses once, then the pattern changes to 0,1 alternation.
- voice_en -> 0 for 3 cycles, then 3'b110:
  - Response: rom_en=0 within 1 cycle; first new issue is voice 1, then 2,1,2.
- ROM_LAT=3, all enabled, rst_n pulsed low mid-run:
  - Response: before reset, the capture-to-issue offset is 4 cycles.
  - Outputs are 0 during reset, with no stale sample_upd after release.
  - The first issue is voice 0.

Source files
------------

// File: rtl/voice_rom_scheduler_if.sv
// -----------------------------------------------------------------------------
// voice_rom_scheduler_if
// Bundles the voice-side inputs, the shared ROM port and the per-voice sample
// outputs of voice_rom_scheduler.
//   voice_en     per-voice enable, bit i = voice i
//   voice_addrs  per-voice ROM address, voice i at [i*ADDR_W +: ADDR_W]
//   rom_en       registered ROM read strobe
//   rom_addr     registered ROM read address
//   rom_data     ROM read data, ROM_LAT cycles after the issue cycle
//   samples      per-voice held sample, voice i at [i*DATA_W +: DATA_W]
//   sample_upd   one-cycle pulse per voice slice update
//   frame_done   one-cycle pulse when the last voice of a pass lands
//   cur_voice    voice index of the current issue
// Modport slave is the scheduler; modport master is the voice/ROM side.
// -----------------------------------------------------------------------------
interface voice_rom_scheduler_if #(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8
);
    logic [NUM_VOICES-1:0]        voice_en;
    logic [NUM_VOICES*ADDR_W-1:0] voice_addrs;
    logic                         rom_en;
    logic [ADDR_W-1:0]            rom_addr;
    logic [DATA_W-1:0]            rom_data;
    logic [NUM_VOICES*DATA_W-1:0] samples;
    logic [NUM_VOICES-1:0]        sample_upd;
    logic                         frame_done;
    logic [2:0]                   cur_voice;

    modport slave (
        input  voice_en, voice_addrs, rom_data,
        output rom_en, rom_addr, samples, sample_upd, frame_done, cur_voice
    );

    modport master (
        output voice_en, voice_addrs, rom_data,
        input  rom_en, rom_addr, samples, sample_upd, frame_done, cur_voice
    );
endinterface

// File: rtl/voice_rom_scheduler.sv
// -----------------------------------------------------------------------------
// voice_rom_scheduler
// Time-shares one synchronous waveform ROM port among NUM_VOICES voices in
// round-robin order. Each cycle one read is issued for the next enabled voice;
// a tag {valid, voice, last} follows the read through the ROM latency and
// steers the returned data into that voice's holding register.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    voice_rom_scheduler_if.slave (voice inputs, ROM port, samples)
// -----------------------------------------------------------------------------
module voice_rom_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    voice_rom_scheduler_if.slave  bus
);
    localparam logic [2:0] LAST_IDX = 3'(NUM_VOICES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [2:0]                      ptr_q, ptr_d;
    logic                            rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]               rom_addr_q, rom_addr_d;
    logic [2:0]                      cur_voice_q, cur_voice_d;
    logic                            last_q, last_d;
    logic [ROM_LAT-1:0]              tag_vld_q, tag_vld_d;
    logic [ROM_LAT-1:0][2:0]         tag_voice_q, tag_voice_d;
    logic [ROM_LAT-1:0]              tag_last_q, tag_last_d;
    logic [NUM_VOICES-1:0][DATA_W-1:0] samples_q, samples_d;
    logic [NUM_VOICES-1:0]           sample_upd_q, sample_upd_d;
    logic                            frame_done_q, frame_done_d;

    logic [7:0]                      en8_s;
    logic [2:0]                      nxt_s;
    logic                            last_s;
    logic [ADDR_W-1:0]               addr_sel_s;
    logic                            cap_vld_s;
    logic [2:0]                      cap_voice_s;

    assign en8_s       = 8'(bus.voice_en);
    assign cap_vld_s   = tag_vld_q[ROM_LAT-1];
    assign cap_voice_s = tag_voice_q[ROM_LAT-1];

    // Round-robin search: first enabled voice after ptr_q, wrapping back to ptr_q itself
    always_comb begin
        logic [3:0] idx_v;
        logic       found_v;
        nxt_s   = ptr_q;
        found_v = 1'b0;
        idx_v   = 4'd0;
        for (int k = 1; k <= NUM_VOICES; k++) begin
            idx_v = 4'(int'(ptr_q) + k);
            if (idx_v >= 4'(NUM_VOICES)) begin
                idx_v = idx_v - 4'(NUM_VOICES);
            end else begin
                idx_v = idx_v;
            end
            if (!found_v && en8_s[idx_v[2:0]]) begin
                nxt_s   = idx_v[2:0];
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
    end

    // Pass-wrap flag and address mux for the selected voice
    always_comb begin
        last_s     = 1'b1;
        addr_sel_s = {ADDR_W{1'b0}};
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (3'(i) > nxt_s && bus.voice_en[i]) begin
                last_s = 1'b0;
            end else begin
                last_s = last_s;
            end
            if (3'(i) == nxt_s) begin
                addr_sel_s = bus.voice_addrs[i*ADDR_W +: ADDR_W];
            end else begin
                addr_sel_s = addr_sel_s;
            end
        end
    end

    // FSM next state and issue registers; leaving RUN re-arms the pointer so voice 0 leads
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        cur_voice_d = cur_voice_q;
        last_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.voice_en != {NUM_VOICES{1'b0}}) state_d = ST_RUN;
                else                                     state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.voice_en == {NUM_VOICES{1'b0}}) state_d = ST_IDLE;
                else                                     state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_RUN) begin
            rom_en_d    = 1'b1;
            rom_addr_d  = addr_sel_s;
            cur_voice_d = nxt_s;
            last_d      = last_s;
            ptr_d       = nxt_s;
        end else begin
            ptr_d       = LAST_IDX;
        end
    end

    // Tag shift register and sample capture; a tag whose voice is now disabled is dropped
    // but still carries its pass-wrap flag to frame_done
    always_comb begin
        tag_vld_d      = tag_vld_q;
        tag_voice_d    = tag_voice_q;
        tag_last_d     = tag_last_q;
        tag_vld_d[0]   = rom_en_q;
        tag_voice_d[0] = cur_voice_q;
        tag_last_d[0]  = last_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_vld_d[i]   = tag_vld_q[i-1];
            tag_voice_d[i] = tag_voice_q[i-1];
            tag_last_d[i]  = tag_last_q[i-1];
        end
        samples_d    = samples_q;
        sample_upd_d = {NUM_VOICES{1'b0}};
        frame_done_d = cap_vld_s & tag_last_q[ROM_LAT-1];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!bus.voice_en[i]) begin
                samples_d[i] = {DATA_W{1'b0}};
            end else if (cap_vld_s && cap_voice_s == 3'(i)) begin
                samples_d[i]    = bus.rom_data;
                sample_upd_d[i] = 1'b1;
            end else begin
                samples_d[i] = samples_q[i];
            end
        end
    end

    // State, issue, tag and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= LAST_IDX;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= {ADDR_W{1'b0}};
            cur_voice_q  <= 3'd0;
            last_q       <= 1'b0;
            tag_vld_q    <= {ROM_LAT{1'b0}};
            tag_voice_q  <= {(ROM_LAT*3){1'b0}};
            tag_last_q   <= {ROM_LAT{1'b0}};
            samples_q    <= {(NUM_VOICES*DATA_W){1'b0}};
            sample_upd_q <= {NUM_VOICES{1'b0}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            cur_voice_q  <= cur_voice_d;
            last_q       <= last_d;
            tag_vld_q    <= tag_vld_d;
            tag_voice_q  <= tag_voice_d;
            tag_last_q   <= tag_last_d;
            samples_q    <= samples_d;
            sample_upd_q <= sample_upd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rom_en     = rom_en_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.cur_voice  = cur_voice_q;
    assign bus.samples    = samples_q;
    assign bus.sample_upd = sample_upd_q;
    assign bus.frame_done = frame_done_q;
endmodule
